// File: rtl/load_store_unit_if.sv
// Request/response handshake plus the word-wide data-memory port of the load/store unit.
// The slave modport is the unit itself; the master modport is the pipeline and memory around it.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] data_add;
  logic [31:0] mem_data_content;
  logic        data_ReadEn;
  logic        data_writeEn;
  logic [31:0] mem_data_out;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_data_out,
    output req_ready, resp_valid, resp_rdata, resp_err,
           data_add, mem_data_content, data_ReadEn, data_writeEn
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready, mem_data_out,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           data_add, mem_data_content, data_ReadEn, data_writeEn
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store unit: turns byte/half/word accesses into word-only memory traffic,
// using read-modify-write for sub-word stores and flagging misaligned or illegal accesses.
module load_store_unit #(
  parameter bit WORD_INDEXED = 1'b1
) (
  input logic            clk,
  input logic            rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [2:0]  funct3_q;
  logic [31:0] buf_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic [31:0] mem_addr;
  logic        mem_active;

  function automatic logic access_err(input logic wr, input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000:  access_err = 1'b0;
      3'b001:  access_err = a[0];
      3'b010:  access_err = (a != 2'b00);
      3'b100:  access_err = wr;
      3'b101:  access_err = wr | a[0];
      default: access_err = 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = w >> {a, 3'b000};
    half_sh = w >> {a[1], 4'b0000};
    case (f3)
      3'b000:  load_extract = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_extract = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  load_extract = {24'h000000, byte_sh[7:0]};
      3'b101:  load_extract = {16'h0000, half_sh[15:0]};
      default: load_extract = w;
    endcase
  endfunction

  // Replace only the addressed lane of the fetched word with the low store bits.
  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] old_w, input logic [31:0] wd);
    logic [31:0] mask;
    logic [31:0] lane;
    if (f3[0]) begin
      mask = 32'h0000FFFF << {a[1], 4'b0000};
      lane = {16'h0000, wd[15:0]} << {a[1], 4'b0000};
    end else begin
      mask = 32'h000000FF << {a, 3'b000};
      lane = {24'h000000, wd[7:0]} << {a, 3'b000};
    end
    store_merge = (old_w & ~mask) | (lane & mask);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      funct3_q <= '0;
      buf_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            funct3_q <= bus.req_funct3;
            buf_q    <= bus.req_wdata;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            if (access_err(bus.req_write, bus.req_funct3, bus.req_addr[1:0])) begin
              err_q <= 1'b1;
              state <= RESP;
            end else if (!bus.req_write) begin
              state <= LOAD;
            end else if (bus.req_funct3 == 3'b010) begin
              state <= WRITE;
            end else begin
              state <= RMW_READ;
            end
          end
        end
        LOAD: begin
          rdata_q <= load_extract(funct3_q, addr_q[1:0], bus.mem_data_out);
          state   <= RESP;
        end
        RMW_READ: begin
          buf_q <= store_merge(funct3_q, addr_q[1:0], bus.mem_data_out, buf_q);
          state <= WRITE;
        end
        WRITE: state <= RESP;
        RESP: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory-side signals decode straight from state so reset kills a pending write at once.
  assign mem_addr   = WORD_INDEXED ? {2'b00, addr_q[31:2]} : {addr_q[31:2], 2'b00};
  assign mem_active = (state == LOAD) || (state == RMW_READ) || (state == WRITE);

  assign bus.req_ready        = (state == IDLE) && !rst;
  assign bus.resp_valid       = (state == RESP);
  assign bus.resp_rdata       = rdata_q;
  assign bus.resp_err         = err_q;
  assign bus.data_add         = mem_active ? mem_addr : 32'h0;
  assign bus.data_ReadEn      = (state == LOAD) || (state == RMW_READ);
  assign bus.data_writeEn     = (state == WRITE);
  assign bus.mem_data_content = (state == WRITE) ? buf_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 16-word word-indexed memory model.
module tb_load_store_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  load_store_unit_if bus ();

  load_store_unit #(.WORD_INDEXED(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:15] = '{2: 32'hA1B2C3D4, default: 32'h0};

  assign bus.mem_data_out = mem[bus.data_add[3:0]];

  always @(posedge clk) begin
    if (bus.data_writeEn && !bus.data_ReadEn) mem[bus.data_add[3:0]] <= bus.mem_data_content;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          lat;
  int          rd_cnt;
  int          wr_cnt;
  logic [31:0] wcontent;
  logic [31:0] radd;
  logic [31:0] rdata;
  logic        err;
  bit          ok;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, watch memory traffic, optionally stall the response, handshake.
  task automatic apply_stimulus(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input bit hold, input int stall);
    ok = 1'b1; rd_cnt = 0; wr_cnt = 0; wcontent = '0; radd = '0;
    @(negedge clk);
    if (bus.req_ready !== 1'b1) ok = 1'b0;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 8) begin
      if (bus.req_ready !== 1'b0) ok = 1'b0;
      if (bus.data_ReadEn) begin
        rd_cnt++;
        radd = bus.data_add;
      end
      if (bus.data_writeEn) begin
        if (bus.data_ReadEn) ok = 1'b0;
        wr_cnt++;
        wcontent = bus.mem_data_content;
      end
      @(negedge clk);
      lat++;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    for (int i = 0; i < stall; i++) begin
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rdata || bus.resp_err !== err ||
          bus.data_ReadEn !== 1'b0 || bus.data_writeEn !== 1'b0 || bus.req_ready !== 1'b0)
        ok = 1'b0;
      @(negedge clk);
    end
    if (bus.resp_valid !== 1'b1 || bus.req_ready !== 1'b0) ok = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    bus.req_valid  = 1'b0;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) ok = 1'b0;
  endtask

  task automatic check_txn(input string tag, input int e_lat, input int e_rd, input int e_wr,
                           input logic [31:0] e_wc, input logic [31:0] e_rdata, input logic e_err);
    check_output({tag, "_latency"}, lat, e_lat);
    check_output({tag, "_read_cycles"}, rd_cnt, e_rd);
    check_output({tag, "_write_cycles"}, wr_cnt, e_wr);
    if (e_wr != 0) check_output({tag, "_write_data"}, wcontent, e_wc);
    check_output({tag, "_rdata"}, rdata, e_rdata);
    check_output({tag, "_err"}, {31'h0, err}, {31'h0, e_err});
    check_output({tag, "_handshake"}, {31'h0, ok}, 32'h1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit quiet;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = 3'b000;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b0;

    @(negedge clk);
    check_output("reset_ctrl", {27'h0, bus.req_ready, bus.resp_valid, bus.resp_err,
                 bus.data_ReadEn, bus.data_writeEn}, 32'h0);
    check_output("reset_rdata", bus.resp_rdata, 32'h0);
    rst = 1'b0;
    #1 check_output("reset_release_ready", {31'h0, bus.req_ready}, 32'h1);

    apply_stimulus(1'b0, 3'b000, 32'h0B, 32'h0, 1'b0, 0);
    check_txn("lb", 2, 1, 0, 32'h0, 32'hFFFFFFA1, 1'b0);
    check_output("lb_data_add", radd, 32'h2);

    apply_stimulus(1'b0, 3'b100, 32'h0B, 32'h0, 1'b0, 0);
    check_txn("lbu", 2, 1, 0, 32'h0, 32'h000000A1, 1'b0);

    apply_stimulus(1'b0, 3'b101, 32'h0A, 32'h0, 1'b0, 0);
    check_txn("lhu", 2, 1, 0, 32'h0, 32'h0000A1B2, 1'b0);

    apply_stimulus(1'b0, 3'b001, 32'h0A, 32'h0, 1'b0, 0);
    check_txn("lh", 2, 1, 0, 32'h0, 32'hFFFFA1B2, 1'b0);

    apply_stimulus(1'b0, 3'b001, 32'h09, 32'h0, 1'b0, 0);
    check_txn("lh_misaligned", 1, 0, 0, 32'h0, 32'h0, 1'b1);

    apply_stimulus(1'b0, 3'b011, 32'h08, 32'h0, 1'b0, 0);
    check_txn("illegal_f3", 1, 0, 0, 32'h0, 32'h0, 1'b1);

    apply_stimulus(1'b1, 3'b010, 32'h0D, 32'hDEADBEEF, 1'b0, 0);
    check_txn("sw_misaligned", 1, 0, 0, 32'h0, 32'h0, 1'b1);

    apply_stimulus(1'b1, 3'b100, 32'h08, 32'hDEADBEEF, 1'b0, 0);
    check_txn("store_unsigned", 1, 0, 0, 32'h0, 32'h0, 1'b1);
    check_output("errors_left_mem", mem[2], 32'hA1B2C3D4);

    apply_stimulus(1'b1, 3'b000, 32'h09, 32'h123456EE, 1'b0, 0);
    check_txn("sb", 3, 1, 1, 32'hA1B2EED4, 32'h0, 1'b0);

    apply_stimulus(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 0);
    check_txn("lw_after_sb", 2, 1, 0, 32'h0, 32'hA1B2EED4, 1'b0);

    apply_stimulus(1'b1, 3'b010, 32'h0C, 32'h12345678, 1'b1, 0);
    check_txn("sw_held", 2, 0, 1, 32'h12345678, 32'h0, 1'b0);

    apply_stimulus(1'b0, 3'b010, 32'h0C, 32'h0, 1'b1, 5);
    check_txn("lw_stall", 2, 1, 0, 32'h0, 32'h12345678, 1'b0);

    // SH at 0x0E, reset lands while the write is pending.
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 32'h0E;
    bus.req_wdata = 32'h0000BEEF; bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    check_output("sh_rmw_read", {31'h0, bus.data_ReadEn}, 32'h1);
    @(negedge clk);
    check_output("sh_write_pending", {31'h0, bus.data_writeEn}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check_output("rst_mid_ctrl", {27'h0, bus.req_ready, bus.resp_valid, bus.resp_err,
                 bus.data_ReadEn, bus.data_writeEn}, 32'h0);
    check_output("rst_mid_add", bus.data_add, 32'h0);
    check_output("rst_mid_wdata", bus.mem_data_content, 32'h0);
    @(negedge clk);
    check_output("rst_mid_mem", mem[3], 32'h12345678);
    rst = 1'b0;
    #1 check_output("rst_mid_ready", {31'h0, bus.req_ready}, 32'h1);
    quiet = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.data_writeEn !== 1'b0) quiet = 1'b0;
    end
    check_output("rst_no_stale_resp", {31'h0, quiet}, 32'h1);

    apply_stimulus(1'b0, 3'b010, 32'h0C, 32'h0, 1'b0, 0);
    check_txn("lw_after_rst", 2, 1, 0, 32'h0, 32'h12345678, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the pipeline's memory stage and data_memory. Owns the data port: data_add, mem_data_content, data_ReadEn, data_writeEn and mem_data_out.
- Converts RISC-V byte, halfword and word loads/stores into word-only memory accesses.
- Loads: byte/halfword lane extraction with sign or zero extension.
- Sub-word stores: read-modify-write sequence.
- Misaligned or illegal accesses: flagged, memory untouched.
- Single outstanding request, valid/ready handshakes on both request and response sides.

Parameters:
- WORD_INDEXED, 1: 1 = data_add = {2'b00, addr[31:2]} (memory indexed by word); 0 = data_add = {addr[31:2], 2'b00}.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, value in low bits
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or illegal access
- data_add  out  32  memory address
- mem_data_content  out  32  memory write data
- data_ReadEn  out  1  memory read enable
- data_writeEn  out  1  memory write enable
- mem_data_out  in  32  memory read data, combinational from data_add

Behaviour:
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- Reset (async): state goes to IDLE. While rst is high, all outputs are 0, including req_ready. Memory-side outputs are combinational from state, so data_writeEn drops in the same cycle rst asserts.
- IDLE:
  - req_ready=1; memory outputs all 0.
  - Accept when req_valid & req_ready; latch addr, funct3, write, wdata.
- Error check at accept:
  - Any of the following sets err: H/HU with addr[0]=1; W with addr[1:0]!=0; funct3 in {011,110,111}; store with funct3 in {100,101}.
  - On err go to RESP with resp_err=1, resp_rdata=0. No memory enable is ever asserted.
- Next state from a legal accept:
  - load -> LOAD
  - SW -> WRITE, with mem_data_content = wdata
  - SB/SH -> RMW_READ
- LOAD:
  - data_ReadEn=1, data_add driven.
  - At clock edge, capture extracted lane into resp_rdata. Lanes are little-endian: byte k=addr[1:0] is bits [8k+7:8k]; half h=addr[1] is bits [16h+15:16h].
  - Sign extension for B/H, zero extension for BU/HU; W passes through.
  - Next state RESP.
- RMW_READ:
  - data_ReadEn=1.
  - Capture mem_data_out with the target lane replaced by wdata[7:0] (SB) or wdata[15:0] (SH) into the write buffer.
  - Next state WRITE.
- WRITE:
  - data_writeEn=1, data_ReadEn=0 (memory writes only when ReadEn is low), mem_data_content = buffer, for exactly one cycle.
  - Next state RESP.
- RESP:
  - resp_valid=1; resp_rdata and resp_err held stable until resp_ready.
  - On resp_valid & resp_ready go to IDLE. req_ready stays 0 throughout RESP (no overlap).
- Latency from accept edge to resp_valid: error 1 cycle; load 2; SW 2; SB/SH 3.
- data_ReadEn and data_writeEn are never both 1.
- data_add is held constant from LOAD/RMW_READ through WRITE.
- Inputs are ignored outside IDLE.
- Reset mid-operation: no partial write. Response is discarded; no resp_valid after reset is released.

Test Plan:
Preload word at byte 0x08 = 0xA1B2C3D4; WORD_INDEXED=1.
- LB addr 0x0B -> data_add=0x2, ReadEn 1 cycle; resp_valid 2 cycles after accept; rdata=0xFFFFFFA1, err=0. LBU 0x0B -> 0x000000A1.
- LHU 0x0A -> 0x0000A1B2. LH 0x09 -> err=1, rdata=0, resp 1 cycle after accept, no ReadEn/writeEn pulse. Illegal funct3 011 -> err=1.
- SB addr 0x09, wdata 0x123456EE -> ReadEn 1 cycle, then writeEn 1 cycle with ReadEn=0 and mem_data_content=0xA1B2EED4; resp 3 cycles after accept; subsequent LW 0x08 -> 0xA1B2EED4.
- SW 0x0C 0x12345678 then LW 0x0C -> 0x12345678. While each response is pending, req_ready=0 and a held req_valid is not accepted.
- resp_ready low for 5 cycles in RESP -> resp_valid, rdata and err stable; no memory enables; accept occurs only after the handshake.
- SH 0x0E, rst asserted during WRITE -> data_writeEn falls in the same cycle (async); memory word unchanged; all outputs 0; after release req_ready=1 and no stale resp_valid.
